// File: rtl/baugh_wooley_divider_8bit_if.sv
// Handshake and operand/result bundle for the signed sequential divider.
interface baugh_wooley_divider_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic             Overflow;

    // Requester side: drives the operation, observes results.
    modport master (
        output Start, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivZero, Overflow
    );

    // Divider side.
    modport slave (
        input  Start, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivZero, Overflow
    );
endinterface

// File: rtl/baugh_wooley_divider_8bit.sv
// Signed restoring shift-subtract divider, one quotient bit per clock.
// Fixed latency: Start accepted at E0, results/Done appear after E0+WIDTH+1.
module baugh_wooley_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    baugh_wooley_divider_8bit_if.slave   io_bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

    state_e            r_state,    w_state_nxt;
    logic [WIDTH:0]    r_rem,      w_rem_nxt;     // partial remainder
    logic [WIDTH-1:0]  r_dvd,      w_dvd_nxt;     // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0]  r_dvs,      w_dvs_nxt;     // divisor magnitude
    logic [WIDTH-1:0]  r_a_raw,    w_a_raw_nxt;   // raw dividend, returned on divide by zero
    logic              r_neg_a,    w_neg_a_nxt;
    logic              r_neg_q,    w_neg_q_nxt;
    logic              r_ez,       w_ez_nxt;      // divide by zero seen at acceptance
    logic              r_eo,       w_eo_nxt;      // -MIN / -1 seen at acceptance
    logic [CntW-1:0]   r_cnt,      w_cnt_nxt;
    logic [WIDTH-1:0]  r_quot,     w_quot_nxt;
    logic [WIDTH-1:0]  r_remo,     w_remo_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_divzero,  w_divzero_nxt;
    logic              r_ovf,      w_ovf_nxt;

    logic [WIDTH+1:0]  w_shift;
    logic [WIDTH+1:0]  w_trial;
    logic [WIDTH-1:0]  w_min_val;

    assign w_min_val = {1'b1, {(WIDTH-1){1'b0}}};
    // Shift {rem, dvd} left by one; extra top bit carries the trial-subtract sign.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial   = w_shift - {2'b00, r_dvs};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_a_raw   <= '0;
            r_neg_a   <= 1'b0;
            r_neg_q   <= 1'b0;
            r_ez      <= 1'b0;
            r_eo      <= 1'b0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_remo    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_dvd     <= w_dvd_nxt;
            r_dvs     <= w_dvs_nxt;
            r_a_raw   <= w_a_raw_nxt;
            r_neg_a   <= w_neg_a_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_ez      <= w_ez_nxt;
            r_eo      <= w_eo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_quot    <= w_quot_nxt;
            r_remo    <= w_remo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_divzero <= w_divzero_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_dvd_nxt     = r_dvd;
        w_dvs_nxt     = r_dvs;
        w_a_raw_nxt   = r_a_raw;
        w_neg_a_nxt   = r_neg_a;
        w_neg_q_nxt   = r_neg_q;
        w_ez_nxt      = r_ez;
        w_eo_nxt      = r_eo;
        w_cnt_nxt     = r_cnt;
        w_quot_nxt    = r_quot;
        w_remo_nxt    = r_remo;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_divzero_nxt = r_divzero;
        w_ovf_nxt     = r_ovf;

        unique case (r_state)
            StIdle, StDone: begin
                if (io_bus.Start) begin
                    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
                    w_dvd_nxt     = io_bus.Dividend[WIDTH-1] ? ('0 - io_bus.Dividend)
                                                             : io_bus.Dividend;
                    w_dvs_nxt     = io_bus.Divisor[WIDTH-1]  ? ('0 - io_bus.Divisor)
                                                             : io_bus.Divisor;
                    w_a_raw_nxt   = io_bus.Dividend;
                    w_neg_a_nxt   = io_bus.Dividend[WIDTH-1];
                    w_neg_q_nxt   = io_bus.Dividend[WIDTH-1] ^ io_bus.Divisor[WIDTH-1];
                    w_ez_nxt      = (io_bus.Divisor == '0);
                    w_eo_nxt      = (io_bus.Dividend == w_min_val) && (&io_bus.Divisor);
                    w_rem_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_divzero_nxt = 1'b0;
                    w_ovf_nxt     = 1'b0;
                    w_state_nxt   = StCalc;
                end else begin
                    w_state_nxt   = StIdle;
                end
            end
            StCalc: begin
                if (!w_trial[WIDTH+1]) begin
                    w_rem_nxt = w_trial[WIDTH:0];
                    w_dvd_nxt = {r_dvd[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem_nxt = w_shift[WIDTH:0];
                    w_dvd_nxt = {r_dvd[WIDTH-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + CntW'(1);
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    w_state_nxt = StSign;
                end
            end
            StSign: begin
                if (r_ez) begin
                    w_quot_nxt = '1;
                    w_remo_nxt = r_a_raw;
                end else if (r_eo) begin
                    w_quot_nxt = w_min_val;
                    w_remo_nxt = '0;
                end else begin
                    w_quot_nxt = r_neg_q ? ('0 - r_dvd) : r_dvd;
                    w_remo_nxt = r_neg_a ? ('0 - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
                end
                w_divzero_nxt = r_ez;
                w_ovf_nxt     = r_eo;
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b1;
                w_state_nxt   = StDone;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign io_bus.Quotient  = r_quot;
    assign io_bus.Remainder = r_remo;
    assign io_bus.Busy      = r_busy;
    assign io_bus.Done      = r_done;
    assign io_bus.DivZero   = r_divzero;
    assign io_bus.Overflow  = r_ovf;
endmodule

// File: tb/tb_baugh_wooley_divider_8bit.sv
// Directed and random-vector bench for the signed sequential divider.
module tb_baugh_wooley_divider_8bit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;

    baugh_wooley_divider_8bit_if #(.WIDTH(8)) bus ();

    baugh_wooley_divider_8bit #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for Done after the accepting edge; checks latency and Busy length.
    task automatic wait_done(input string tag);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        while (!bus.Done && lat < 20) begin
            if (bus.Busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " busy_cycles"}, busy_n, 9);
        check({tag, " busy_at_done"}, {31'd0, bus.Busy}, 0);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Dividend = a;
        bus.Divisor  = b;
        @(posedge clk); #1;
        bus.Start    = 1'b0;
    endtask

    task automatic div_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] eq, input logic [7:0] er,
                             input logic edz, input logic eov);
        start_op(a, b);
        wait_done(tag);
        check({tag, " q"}, {24'd0, bus.Quotient}, {24'd0, eq});
        check({tag, " r"}, {24'd0, bus.Remainder}, {24'd0, er});
        check({tag, " flags"}, {30'd0, bus.DivZero, bus.Overflow}, {30'd0, edz, eov});
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, bus.Done}, 0);
        check({tag, " hold"}, {16'd0, bus.Quotient, bus.Remainder}, {16'd0, eq, er});
    endtask

    initial begin
        bit saw_done;
        n_checks     = 0;
        n_errs       = 0;
        rst_n        = 1'b0;
        bus.Start    = 1'b1;   // reset must win over a concurrent Start
        bus.Dividend = 8'h64;
        bus.Divisor  = 8'h07;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {14'd0, bus.Quotient, bus.Remainder, bus.Busy, bus.Done},
              32'd0);
        check("reset flags", {30'd0, bus.DivZero, bus.Overflow}, 0);
        bus.Start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;

        div_check("100/7",    8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);
        div_check("-100/7",   8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
        div_check("100/-7",   8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
        div_check("-100/-7",  8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
        div_check("-128/-1",  8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        div_check("-128/1",   8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
        div_check("127/-128", 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0);
        div_check("-128/-128", 8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
        div_check("5/0",      8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0);
        // DivZero must drop as soon as the next op is accepted.
        start_op(8'h64, 8'h07);
        check("divzero_clr_at_start", {31'd0, bus.DivZero}, 0);
        wait_done("after_dz");
        check("after_dz qr", {16'd0, bus.Quotient, bus.Remainder}, 32'h0E02);

        // Start re-pulsed with other operands while busy is ignored.
        start_op(8'h64, 8'h07);
        repeat (2) @(posedge clk);
        #1;
        bus.Start    = 1'b1;
        bus.Dividend = 8'h32;
        bus.Divisor  = 8'h03;
        @(posedge clk); #1;
        bus.Start    = 1'b0;
        saw_done     = 1'b0;
        for (int i = 0; i < 20 && !saw_done; i++) begin
            if (bus.Done) saw_done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("ignore done_seen", {31'd0, saw_done}, 1);
        check("ignore qr", {16'd0, bus.Quotient, bus.Remainder}, 32'h0E02);

        // Start held high through Done: second op accepted back-to-back.
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Dividend = 8'h64;
        bus.Divisor  = 8'h07;
        @(posedge clk); #1;
        bus.Dividend = 8'h9C;
        wait_done("b2b first");
        check("b2b first qr", {16'd0, bus.Quotient, bus.Remainder}, 32'h0E02);
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("b2b accepted busy", {30'd0, bus.Busy, bus.Done}, 32'd2);
        wait_done("b2b second");
        check("b2b second qr", {16'd0, bus.Quotient, bus.Remainder}, 32'hF2FE);

        // Reset during CALC aborts with no Done.
        start_op(8'h64, 8'h07);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset outs", {14'd0, bus.Quotient, bus.Remainder, bus.Busy, bus.Done},
              32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (bus.Done || bus.Busy) saw_done = 1'b1;
        end
        check("midreset no_done", {31'd0, saw_done}, 0);
        div_check("post_reset 100/7", 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);

        // Random operand pairs against a C-semantics reference model.
        for (int k = 0; k < 2500; k++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [7:0] eq;
            logic [7:0] er;
            logic       edz;
            logic       eov;
            int         sa;
            int         sb;
            a   = 8'($urandom);
            b   = (k % 97 == 0) ? 8'h00 : 8'($urandom);
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            edz = 1'b0;
            eov = 1'b0;
            if (sb == 0) begin
                eq  = 8'hFF;
                er  = a;
                edz = 1'b1;
            end else if (sa == -128 && sb == -1) begin
                eq  = 8'h80;
                er  = 8'h00;
                eov = 1'b1;
            end else begin
                eq  = 8'(sa / sb);
                er  = 8'(sa % sb);
            end
            start_op(a, b);
            wait_done("rand");
            check("rand result",
                  {14'd0, bus.Quotient, bus.Remainder, bus.DivZero, bus.Overflow},
                  {14'd0, eq, er, edz, eov});
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
